guess_judge: RTL and testbench

GUESS_JUDGE -- requirements
Module: guess_judge

---
 rtl/judge_pkg.sv | 13 +
 rtl/digit_match.sv | 22 ++
 rtl/guess_judge.sv | 148 ++++++++++++++
 tb/tb_guess_judge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/judge_pkg.sv
// Shared types and sizes for the bulls-and-cows guess judge.
package judge_pkg;
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int CNT_W      = 3;
  localparam int IDX_W      = 2;
  localparam int TRIES_W    = 4;

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  // Index 0 is the leftmost digit.
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;
endpackage

// File: rtl/digit_match.sv
// Classifies one guess digit against the secret: exact position hit (A)
// or present elsewhere (B); never both.
module digit_match
  import judge_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic [IDX_W-1:0]   idx,
  input  digits_t            secret,
  output logic               hit_a,
  output logic               hit_b
);
  logic present;

  always_comb begin
    present = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (secret[j] == digit) present = 1'b1;
    end
    hit_a = (secret[idx] == digit);
    hit_b = present && !hit_a;
  end
endmodule

// File: rtl/guess_judge.sv
// Judges a 4-digit BCD guess against a secret, one position per cycle; done 5 cycles after start.
// start while busy is dropped; clear aborts any judgement. Macro ROUND_LIMIT_EN enables the attempt limit.
module guess_judge
  import judge_pkg::*;
#(
  parameter int MAX_TRIES = 10
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIGIT_W-1:0] g0,
  input  logic [DIGIT_W-1:0] g1,
  input  logic [DIGIT_W-1:0] g2,
  input  logic [DIGIT_W-1:0] g3,
  input  logic [DIGIT_W-1:0] s0,
  input  logic [DIGIT_W-1:0] s1,
  input  logic [DIGIT_W-1:0] s2,
  input  logic [DIGIT_W-1:0] s3,
  input  logic               clear,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   a_cnt,
  output logic [CNT_W-1:0]   b_cnt,
  output logic               win,
  output logic               invalid,
  output logic [TRIES_W-1:0] tries,
  output logic               lose
);
`ifdef ROUND_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [TRIES_W-1:0] TRIES_SAT = '1;
  localparam logic [TRIES_W-1:0] LIMIT     = TRIES_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0]   ALL_HIT   = CNT_W'(NUM_DIGITS);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIGIT_W-1:0] MAX_BCD   = DIGIT_W'(9);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  digits_t              g_q, s_q;
  logic [CNT_W-1:0]     a_acc, b_acc;
  logic                 hit_a, hit_b;
  logic                 bad_guess;
  logic                 lose_q;
  logic                 accept;
  logic [TRIES_W-1:0]   tries_inc;

  digit_match u_match (
    .digit  (g_q[idx]),
    .idx    (idx),
    .secret (s_q),
    .hit_a  (hit_a),
    .hit_b  (hit_b)
  );

  // A finished game (win or lose) locks out new guesses only when the limit is enabled.
  assign accept    = start && !clear && !(LIMIT_EN && (lose_q || win));
  assign busy      = (state != IDLE);
  assign lose      = LIMIT_EN ? lose_q : 1'b0;
  assign tries_inc = (tries == TRIES_SAT) ? TRIES_SAT : tries + 1'b1;

  always_comb begin
    bad_guess = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (g_q[i] > MAX_BCD) bad_guess = 1'b1;
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (g_q[i] == g_q[j]) bad_guess = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CHECK;
      CHECK:   if (clear) state_nxt = IDLE;
               else if (idx == LAST_IDX) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      g_q     <= '0;
      s_q     <= '0;
      a_acc   <= '0;
      b_acc   <= '0;
      done    <= 1'b0;
      a_cnt   <= '0;
      b_cnt   <= '0;
      win     <= 1'b0;
      invalid <= 1'b0;
      tries   <= '0;
      lose_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          g_q     <= {g3, g2, g1, g0};
          s_q     <= {s3, s2, s1, s0};
          a_acc   <= '0;
          b_acc   <= '0;
          idx     <= '0;
          win     <= 1'b0;
          invalid <= 1'b0;
        end
        CHECK: if (!clear) begin
          a_acc <= a_acc + CNT_W'(hit_a);
          b_acc <= b_acc + CNT_W'(hit_b);
          idx   <= idx + 1'b1;
        end
        REPORT: if (!clear) begin
          done <= 1'b1;
          if (bad_guess) begin
            a_cnt   <= '0;
            b_cnt   <= '0;
            win     <= 1'b0;
            invalid <= 1'b1;
          end else begin
            a_cnt   <= a_acc;
            b_cnt   <= b_acc;
            win     <= (a_acc == ALL_HIT);
            invalid <= 1'b0;
            tries   <= tries_inc;
            lose_q  <= LIMIT_EN && (a_acc != ALL_HIT) && (tries_inc >= LIMIT);
          end
        end
        default: ;
      endcase
      if (clear) begin
        tries  <= '0;
        lose_q <= 1'b0;
        win    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_guess_judge.sv
// Directed bench for guess_judge; secret fixed at 1234, MAX_TRIES=3.
module tb_guess_judge;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] g0 = 4'd0, g1 = 4'd0, g2 = 4'd0, g3 = 4'd0;
  logic [3:0] s0 = 4'd1, s1 = 4'd2, s2 = 4'd3, s3 = 4'd4;
  logic       busy, done, win, invalid, lose;
  logic [2:0] a_cnt, b_cnt;
  logic [3:0] tries;

  int checks = 0;
  int errors = 0;

`ifdef ROUND_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  guess_judge #(.MAX_TRIES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .g0(g0), .g1(g1), .g2(g2), .g3(g3),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .clear(clear), .busy(busy), .done(done),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .win(win), .invalid(invalid),
    .tries(tries), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic set_guess(input logic [3:0] d0, d1, d2, d3);
    g0 = d0; g1 = d1; g2 = d2; g3 = d3;
  endtask

  // Returns cycles from the start edge to the first done, or -1 on timeout.
  task automatic run_guess(input logic [3:0] d0, d1, d2, d3, output int lat);
    set_guess(d0, d1, d2, d3);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({a_cnt, b_cnt} !== 6'd0) begin errors++; $display("FAIL reset_ab: got %0d/%0d want 0/0", a_cnt, b_cnt); end
    checks++; if ({win, invalid, lose} !== 3'b000) begin errors++; $display("FAIL reset_flags: got win=%b inv=%b lose=%b want 000", win, invalid, lose); end
    checks++; if (tries !== 4'd0)   begin errors++; $display("FAIL reset_tries: got %0d want 0", tries); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exact();
    int lat;
    set_guess(4'd1, 4'd2, 4'd3, 4'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exact_busy: got %b want 1", busy); end
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL exact_latency: got %0d want 5", lat); end
    checks++; if (a_cnt !== 3'd4 || b_cnt !== 3'd0) begin errors++; $display("FAIL exact_ab: got %0d/%0d want 4/0", a_cnt, b_cnt); end
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL exact_win: got %b want 1", win); end
    checks++; if (tries !== 4'd1) begin errors++; $display("FAIL exact_tries: got %0d want 1", tries); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exact_busy_end: got %b want 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL exact_done_pulse: got %b want 0", done); end
    checks++; if (a_cnt !== 3'd4 || win !== 1'b1) begin errors++; $display("FAIL exact_hold: got a=%0d win=%b want 4/1", a_cnt, win); end
    do_clear();
    checks++; if (tries !== 4'd0 || win !== 1'b0) begin errors++; $display("FAIL exact_clear: got tries=%0d win=%b want 0/0", tries, win); end
  endtask

  task automatic test_patterns();
    int lat;
    do_clear();
    run_guess(4'd4, 4'd3, 4'd2, 4'd1, lat);
    checks++; if (lat !== 5 || a_cnt !== 3'd0 || b_cnt !== 3'd4) begin errors++; $display("FAIL pat_4321: got lat=%0d a=%0d b=%0d want 5/0/4", lat, a_cnt, b_cnt); end
    run_guess(4'd1, 4'd2, 4'd4, 4'd3, lat);
    checks++; if (lat !== 5 || a_cnt !== 3'd2 || b_cnt !== 3'd2 || win !== 1'b0) begin errors++; $display("FAIL pat_1243: got lat=%0d a=%0d b=%0d win=%b want 5/2/2/0", lat, a_cnt, b_cnt, win); end
    run_guess(4'd5, 4'd6, 4'd7, 4'd8, lat);
    checks++; if (lat !== 5 || a_cnt !== 3'd0 || b_cnt !== 3'd0) begin errors++; $display("FAIL pat_5678: got lat=%0d a=%0d b=%0d want 5/0/0", lat, a_cnt, b_cnt); end
    checks++; if (tries !== 4'd3) begin errors++; $display("FAIL pat_tries: got %0d want 3", tries); end
    checks++; if (lose !== LIM) begin errors++; $display("FAIL pat_lose: got %b want %b", lose, LIM); end
    run_guess(4'd1, 4'd2, 4'd3, 4'd4, lat);
    checks++; if (lat !== (LIM ? -1 : 5)) begin errors++; $display("FAIL pat_fourth_lat: got %0d want %0d", lat, LIM ? -1 : 5); end
    checks++; if (tries !== (LIM ? 4'd3 : 4'd4)) begin errors++; $display("FAIL pat_fourth_tries: got %0d want %0d", tries, LIM ? 3 : 4); end
    do_clear();
    checks++; if (tries !== 4'd0 || lose !== 1'b0) begin errors++; $display("FAIL pat_clear: got tries=%0d lose=%b want 0/0", tries, lose); end
  endtask

  task automatic test_invalid();
    int lat;
    do_clear();
    run_guess(4'd5, 4'd6, 4'd7, 4'd8, lat);
    run_guess(4'd1, 4'd1, 4'd2, 4'd3, lat);
    checks++; if (lat !== 5 || invalid !== 1'b1 || a_cnt !== 3'd0 || b_cnt !== 3'd0 || win !== 1'b0) begin errors++; $display("FAIL inv_dup: got lat=%0d inv=%b a=%0d b=%0d win=%b want 5/1/0/0/0", lat, invalid, a_cnt, b_cnt, win); end
    checks++; if (tries !== 4'd1) begin errors++; $display("FAIL inv_dup_tries: got %0d want 1", tries); end
    run_guess(4'd1, 4'd2, 4'hA, 4'd4, lat);
    checks++; if (lat !== 5 || invalid !== 1'b1 || a_cnt !== 3'd0 || b_cnt !== 3'd0) begin errors++; $display("FAIL inv_hex: got lat=%0d inv=%b a=%0d b=%0d want 5/1/0/0", lat, invalid, a_cnt, b_cnt); end
    checks++; if (tries !== 4'd1) begin errors++; $display("FAIL inv_hex_tries: got %0d want 1", tries); end
    run_guess(4'd4, 4'd3, 4'd2, 4'd1, lat);
    checks++; if (invalid !== 1'b0 || b_cnt !== 3'd4 || tries !== 4'd2) begin errors++; $display("FAIL inv_recover: got inv=%b b=%0d tries=%0d want 0/4/2", invalid, b_cnt, tries); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_clear();
    set_guess(4'd1, 4'd2, 4'd3, 4'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 2) begin set_guess(4'd5, 4'd6, 4'd7, 4'd8); start = 1'b1; end
      tick();
      start = 1'b0;
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    checks++; if (a_cnt !== 3'd4 || tries !== 4'd1) begin errors++; $display("FAIL b2b_result: got a=%0d tries=%0d want 4/1", a_cnt, tries); end
    do_clear();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    set_guess(4'd1, 4'd2, 4'd4, 4'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, win, invalid, lose} !== 5'b0 || a_cnt !== 3'd0 || b_cnt !== 3'd0 || tries !== 4'd0) begin errors++; $display("FAIL rstmid_outputs: got busy=%b done=%b a=%0d b=%0d tries=%0d", busy, done, a_cnt, b_cnt, tries); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got pulses=%0d busy=%b want 0/0", pulses, busy); end
  endtask

  task automatic test_clear_start();
    int lat;
    int pulses = 0;
    run_guess(4'd5, 4'd6, 4'd7, 4'd8, lat);
    checks++; if (tries !== 4'd1) begin errors++; $display("FAIL clrst_pre: got tries=%0d want 1", tries); end
    tick();
    set_guess(4'd1, 4'd2, 4'd3, 4'd4);
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clrst_busy: got %b want 0", busy); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || tries !== 4'd0) begin errors++; $display("FAIL clrst_result: got pulses=%0d tries=%0d want 0/0", pulses, tries); end
  endtask

  task automatic test_clear_abort();
    int lat;
    int pulses = 0;
    run_guess(4'd5, 4'd6, 4'd7, 4'd8, lat);
    set_guess(4'd4, 4'd3, 4'd2, 4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    do_clear();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || tries !== 4'd0 || b_cnt !== 3'd0) begin errors++; $display("FAIL abort_result: got pulses=%0d tries=%0d b=%0d want 0/0/0", pulses, tries, b_cnt); end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_patterns();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_clear_start();
    test_clear_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
